msdap_ctrl: RTL and testbench
=============================

MSDAP_CTRL -- requirements
Module: msdap_ctrl

Interface
REQ-001 SHALL have parameter RJ_N, default 16: number of Rj words loaded after init.
REQ-002 SHALL have parameter COEF_N, default 512: number of coefficient words loaded after the Rj words.
REQ-003 SHALL have parameter DATA_N, default 256: data buffer depth, power of two.
REQ-004 SHALL have port SCLK, input, 1: system clock; only clock in the block.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_pulse, input, 1: one-SCLK pulse per received stereo word.
REQ-007 SHALL have port sample_is_zero, input, 1: both channels of the current word are zero; valid with frame_pulse.
REQ-008 SHALL have port clear_req, input, 1: functional clear request, active-high, sampled on SCLK.
REQ-009 SHALL have port all_zeros, input, 1: long-silence flag from the zero detector.
REQ-010 SHALL have port state, output, 3: current state encoding.
REQ-011 SHALL have ports rj_we / coef_we / data_we, output, 1 each: memory write strobes.
REQ-012 SHALL have ports rj_addr / coef_addr / data_addr, output, clog2 of RJ_N / COEF_N / DATA_N: write addresses.
REQ-013 SHALL have port data_zero, output, 1: write zero instead of the input word.
REQ-014 SHALL have ports in_ready, det_clear and compute_start, output, 1 each: in_ready = accepting words; det_clear = detector clear pulse; compute_start = one-cycle filter start.

Function
REQ-015 SHALL implement states INIT=0, READ_RJ=1, READ_COEF=2, WAIT_INPUT=3, WORKING=4, CLEARING=5, SLEEPING=6.
REQ-016 INIT SHALL assert data_we and data_zero for DATA_N consecutive cycles, data_addr 0..DATA_N-1, then enter READ_RJ with data_addr=0.
REQ-017 Each frame_pulse in READ_RJ SHALL produce rj_we for exactly one cycle, registered one cycle after frame_pulse, at rj_addr; rj_addr increments after the write.
REQ-018 The RJ_N-th Rj write SHALL move the FSM to READ_COEF; coefficient loading SHALL mirror REQ-017 with coef_we/coef_addr; the COEF_N-th write SHALL move the FSM to WAIT_INPUT.
REQ-019 In WAIT_INPUT, WORKING and SLEEPING, each frame_pulse SHALL produce data_we one cycle later at data_addr, with data_zero=0.
REQ-020 data_addr SHALL then increment, wrapping DATA_N-1 -> 0.
REQ-021 compute_start SHALL pulse for one cycle, one cycle after every data_we in WORKING, and after the waking write in SLEEPING.
REQ-022 A frame_pulse in WAIT_INPUT SHALL enter WORKING.
REQ-023 clear_req in WAIT_INPUT, WORKING or SLEEPING SHALL enter CLEARING and pulse det_clear for one cycle.
REQ-024 clear_req SHALL take priority over a simultaneous frame_pulse; that word is discarded (no data_we).
REQ-025 CLEARING SHALL zero the data buffer as in INIT, then enter WAIT_INPUT with data_addr=0.
REQ-026 Rj and coefficient memories SHALL NOT be cleared by CLEARING.
REQ-027 clear_req SHALL be ignored in INIT, READ_RJ, READ_COEF and CLEARING.
REQ-028 all_zeros=1 in WORKING, with no clear_req, SHALL enter SLEEPING.
REQ-029 SLEEPING SHALL keep writing the data buffer on each frame_pulse.
REQ-030 A frame_pulse with sample_is_zero=0 in SLEEPING SHALL write, return to WORKING and pulse compute_start and det_clear.
REQ-031 in_ready SHALL be 1 in READ_RJ, READ_COEF, WAIT_INPUT, WORKING and SLEEPING, and 0 otherwise.
REQ-032 A frame_pulse while in_ready=0 SHALL be ignored.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_n=0 SHALL immediately force state=INIT, all addresses 0, and all strobes, data_zero and det_clear to 0, including mid-load and mid-clear.
REQ-035 in_ready SHALL be 0 during reset.
REQ-036 After rst_n rises, INIT SHALL start on the next SCLK edge.

Configuration
REQ-037 With MSDAP_SLEEP_EN defined, SLEEPING SHALL behave per REQ-028..REQ-030.
REQ-038 Without MSDAP_SLEEP_EN, all_zeros SHALL be ignored, SLEEPING SHALL be unreachable, and det_clear SHALL pulse only on clear_req.

Verification
REQ-039 Release rst_n -> exactly 256 data_we cycles with data_zero=1 at addr 0..255, then state=1, in_ready=1.
REQ-040 16 frame_pulses then 512 frame_pulses -> 16 rj_we (addr 0..15), 512 coef_we (addr 0..511), state=3.
REQ-041 300 frame_pulses after load -> data_addr wraps 255->0 at the 257th word; 300 compute_start pulses, each 2 cycles after its frame_pulse.
REQ-042 clear_req together with a frame_pulse in WORKING -> no data_we for that word, one det_clear, 256 zero writes, state=3, coef memory untouched.
REQ-043 With MSDAP_SLEEP_EN: all_zeros=1 -> state=6; zero words are written with no compute_start; a nonzero word -> state=4, compute_start=1. Without the macro: state stays 4.
REQ-044 rst_n=0 during coefficient word 200 -> state=0 and coef_addr=0 asynchronously; the full reload sequence restarts.

Source files
------------

// File: rtl/msdap_ctrl.sv
// msdap_ctrl: sequencing controller for the MSDAP front end.
// Zeroes the data buffer, loads Rj and coefficient words, then writes incoming
// samples into a circular data buffer and fires the filter once per word.
// Optional feature: define MSDAP_SLEEP_EN to enable the SLEEPING state, which
// is entered on a long run of silence and left on the first nonzero word.
module msdap_ctrl #(
  parameter int RJ_N   = 16,
  parameter int COEF_N = 512,
  parameter int DATA_N = 256
) (
  input  logic                      SCLK,
  input  logic                      rst_n,
  input  logic                      frame_pulse,
  input  logic                      sample_is_zero,
  input  logic                      clear_req,
  input  logic                      all_zeros,
  output logic [2:0]                state,
  output logic                      rj_we,
  output logic                      coef_we,
  output logic                      data_we,
  output logic [$clog2(RJ_N)-1:0]   rj_addr,
  output logic [$clog2(COEF_N)-1:0] coef_addr,
  output logic [$clog2(DATA_N)-1:0] data_addr,
  output logic                      data_zero,
  output logic                      in_ready,
  output logic                      det_clear,
  output logic                      compute_start
);

  localparam int RJ_W = $clog2(RJ_N);
  localparam int CF_W = $clog2(COEF_N);
  localparam int DT_W = $clog2(DATA_N);
  localparam logic [RJ_W-1:0] RJ_LAST   = RJ_W'(RJ_N - 1);
  localparam logic [CF_W-1:0] COEF_LAST = CF_W'(COEF_N - 1);
  localparam logic [DT_W-1:0] DATA_LAST = DT_W'(DATA_N - 1);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_READ_RJ    = 3'd1,
    S_READ_COEF  = 3'd2,
    S_WAIT_INPUT = 3'd3,
    S_WORKING    = 3'd4,
    S_CLEARING   = 3'd5,
    S_SLEEPING   = 3'd6
  } state_e;

  state_e          state_q;
  logic [RJ_W-1:0] rj_addr_q;
  logic [CF_W-1:0] coef_addr_q;
  logic [DT_W-1:0] data_addr_q;
  logic            rj_we_q, coef_we_q, data_we_q, data_zero_q;
  logic            in_ready_q, det_clear_q, compute_start_q, cs_pend_q;

  // Address after the write currently on the bus (wraps at the memory depth).
  logic [RJ_W-1:0] rj_nxt, rj_idx;
  logic [CF_W-1:0] coef_nxt, coef_idx;
  logic [DT_W-1:0] data_nxt;
  logic            accept_clr;

  assign rj_nxt   = (rj_addr_q == RJ_LAST) ? '0 : rj_addr_q + 1'b1;
  assign coef_nxt = (coef_addr_q == COEF_LAST) ? '0 : coef_addr_q + 1'b1;
  assign data_nxt = (data_addr_q == DATA_LAST) ? '0 : data_addr_q + 1'b1;
  // Slot the word accepted this cycle lands in; covers back-to-back pulses
  // where the previous write's increment has not landed yet.
  assign rj_idx   = rj_we_q ? rj_nxt : rj_addr_q;
  assign coef_idx = coef_we_q ? coef_nxt : coef_addr_q;

  // Clear is honoured only once the block is running on live samples.
  assign accept_clr = clear_req && (state_q == S_WAIT_INPUT || state_q == S_WORKING ||
                                    state_q == S_SLEEPING);

`ifndef MSDAP_SLEEP_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, all_zeros, sample_is_zero};
`endif

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_INIT;
      rj_addr_q       <= '0;
      coef_addr_q     <= '0;
      data_addr_q     <= '0;
      rj_we_q         <= 1'b0;
      coef_we_q       <= 1'b0;
      data_we_q       <= 1'b0;
      data_zero_q     <= 1'b0;
      in_ready_q      <= 1'b0;
      det_clear_q     <= 1'b0;
      compute_start_q <= 1'b0;
      cs_pend_q       <= 1'b0;
    end else begin
      rj_we_q         <= 1'b0;
      coef_we_q       <= 1'b0;
      data_we_q       <= 1'b0;
      det_clear_q     <= 1'b0;
      cs_pend_q       <= 1'b0;
      compute_start_q <= cs_pend_q;
      if (rj_we_q)   rj_addr_q   <= rj_nxt;
      if (coef_we_q) coef_addr_q <= coef_nxt;
      if (data_we_q) data_addr_q <= data_nxt;

      if (accept_clr) begin
        // The word arriving with the clear is dropped; sweep restarts at 0.
        state_q     <= S_CLEARING;
        det_clear_q <= 1'b1;
        in_ready_q  <= 1'b0;
        data_addr_q <= '0;
      end else begin
        case (state_q)
          S_INIT, S_CLEARING: begin
            data_we_q   <= 1'b1;
            data_zero_q <= 1'b1;
            if (data_we_q && data_addr_q == DATA_LAST) begin
              data_we_q   <= 1'b0;
              data_zero_q <= 1'b0;
              data_addr_q <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= (state_q == S_INIT) ? S_READ_RJ : S_WAIT_INPUT;
            end
          end
          S_READ_RJ: if (frame_pulse) begin
            rj_we_q <= 1'b1;
            if (rj_idx == RJ_LAST) state_q <= S_READ_COEF;
          end
          S_READ_COEF: if (frame_pulse) begin
            coef_we_q <= 1'b1;
            if (coef_idx == COEF_LAST) state_q <= S_WAIT_INPUT;
          end
          S_WAIT_INPUT, S_WORKING: begin
            if (frame_pulse) begin
              data_we_q <= 1'b1;
              cs_pend_q <= 1'b1;
              state_q   <= S_WORKING;
            end
`ifdef MSDAP_SLEEP_EN
            if (state_q == S_WORKING && all_zeros) state_q <= S_SLEEPING;
`endif
          end
`ifdef MSDAP_SLEEP_EN
          // Keep filling the buffer while asleep; a nonzero word wakes the filter.
          S_SLEEPING: if (frame_pulse) begin
            data_we_q <= 1'b1;
            if (!sample_is_zero) begin
              state_q     <= S_WORKING;
              cs_pend_q   <= 1'b1;
              det_clear_q <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign state         = state_q;
  assign rj_we         = rj_we_q;
  assign coef_we       = coef_we_q;
  assign data_we       = data_we_q;
  assign rj_addr       = rj_addr_q;
  assign coef_addr     = coef_addr_q;
  assign data_addr     = data_addr_q;
  assign data_zero     = data_zero_q;
  assign in_ready      = in_ready_q;
  assign det_clear     = det_clear_q;
  assign compute_start = compute_start_q;

endmodule

// File: tb/tb_msdap_ctrl.sv
// tb_msdap_ctrl: directed sequence with randomized word gaps and zero flags,
// checked against queue-based expectations derived from the block's rules.
`timescale 1ns/1ps
module tb_msdap_ctrl;
  localparam int RJ_N = 16, COEF_N = 512, DATA_N = 256;
`ifdef MSDAP_SLEEP_EN
  localparam bit SLEEP_EN = 1'b1;
`else
  localparam bit SLEEP_EN = 1'b0;
`endif

  logic       SCLK = 1'b0, rst_n = 1'b0;
  logic       frame_pulse = 1'b0, sample_is_zero = 1'b0, clear_req = 1'b0, all_zeros = 1'b0;
  logic [2:0] state;
  logic       rj_we, coef_we, data_we, data_zero, in_ready, det_clear, compute_start;
  logic [3:0] rj_addr;
  logic [8:0] coef_addr;
  logic [7:0] data_addr;

  int ntests = 0, nfail = 0, cyc = 0, n_det = 0;
  int dq_addr[$], dq_cyc[$], rjq[$], cfq[$], csq[$], pq[$];
  bit dq_zero[$];
  bit zs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  msdap_ctrl #(.RJ_N(RJ_N), .COEF_N(COEF_N), .DATA_N(DATA_N)) dut (
    .SCLK(SCLK), .rst_n(rst_n), .frame_pulse(frame_pulse), .sample_is_zero(sample_is_zero),
    .clear_req(clear_req), .all_zeros(all_zeros), .state(state),
    .rj_we(rj_we), .coef_we(coef_we), .data_we(data_we),
    .rj_addr(rj_addr), .coef_addr(coef_addr), .data_addr(data_addr),
    .data_zero(data_zero), .in_ready(in_ready), .det_clear(det_clear),
    .compute_start(compute_start));

  always #5 SCLK = ~SCLK;

  always @(posedge SCLK) cyc <= cyc + 1;

  // Event log of everything the controller drives toward the memories/filter.
  always @(negedge SCLK) begin
    if (data_we) begin
      dq_addr.push_back(int'(data_addr));
      dq_zero.push_back(data_zero);
      dq_cyc.push_back(cyc);
    end
    if (rj_we)         rjq.push_back(int'(rj_addr));
    if (coef_we)       cfq.push_back(int'(coef_addr));
    if (compute_start) csq.push_back(cyc);
    if (det_clear)     n_det <= n_det + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One word: pulse for a cycle, then `gap` idle cycles; ends #1 after an edge.
  task automatic send_word(input bit z, input int gap);
    @(posedge SCLK); #1;
    frame_pulse = 1'b1; sample_is_zero = z; pq.push_back(cyc);
    @(posedge SCLK); #1;
    frame_pulse = 1'b0; sample_is_zero = 1'b0;
    repeat (gap) begin @(posedge SCLK); #1; end
  endtask

  task automatic wait_state(input int s, input int maxc, input string tag);
    int n = 0;
    while (int'(state) != s && n < maxc) begin @(negedge SCLK); n++; end
    chk(tag, state, s);
  endtask

  // A zeroing sweep must be DATA_N back-to-back zero writes at 0..DATA_N-1.
  task automatic check_sweep(input string tag, input int d0);
    int n, bad;
    n = dq_addr.size() - d0;
    bad = 0;
    chk({tag, " count"}, n, DATA_N);
    for (int i = 0; i < n; i++)
      if (dq_addr[d0+i] != i || dq_zero[d0+i] != 1'b1 || dq_cyc[d0+i] != dq_cyc[d0] + i) bad++;
    chk({tag, " zero writes"}, bad, 0);
  endtask

  initial begin
    int d0, r0, c0, s0, n0, bad, rel, wptr, exp_cs, exp_det;
    bit asleep;

    // Reset state
    repeat (3) @(negedge SCLK);
    chk("rst state", state, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst addrs", {rj_addr, coef_addr, data_addr}, 0);
    chk("rst strobes", {rj_we, coef_we, data_we, data_zero, det_clear, compute_start}, 0);

    // INIT sweep starts on the first edge after release
    d0 = dq_addr.size();
    @(posedge SCLK); #1 rst_n = 1'b1; rel = cyc;
    wait_state(1, 400, "init done");
    check_sweep("init", d0);
    chk("init start cycle", (dq_addr.size() > d0) ? dq_cyc[d0] : -1, rel + 1);
    chk("init in_ready", in_ready, 1);
    chk("init data_addr", data_addr, 0);

    // Rj then coefficient load; a clear_req while loading must be ignored
    r0 = rjq.size(); c0 = cfq.size(); n0 = n_det;
    for (int i = 0; i < RJ_N; i++) begin
      send_word(1'($urandom_range(0, 1)), $urandom_range(0, 2));
      if (i == 5) begin
        @(posedge SCLK); #1 clear_req = 1'b1;
        @(posedge SCLK); #1 clear_req = 1'b0;
      end
    end
    chk("rj done state", state, 2);
    for (int i = 0; i < COEF_N; i++) send_word(1'($urandom_range(0, 1)), $urandom_range(0, 2));
    repeat (2) @(negedge SCLK);
    chk("load state", state, 3);
    chk("rj count", rjq.size() - r0, RJ_N);
    chk("coef count", cfq.size() - c0, COEF_N);
    bad = 0;
    for (int i = 0; i < rjq.size() - r0; i++) if (rjq[r0+i] != i % RJ_N) bad++;
    chk("rj addrs", bad, 0);
    bad = 0;
    for (int i = 0; i < cfq.size() - c0; i++) if (cfq[c0+i] != i % COEF_N) bad++;
    chk("coef addrs", bad, 0);
    chk("clear ignored in load", n_det - n0, 0);

    // 300 live words: circular buffer, compute_start two cycles after each pulse
    d0 = dq_addr.size(); s0 = csq.size(); pq.delete(); wptr = 0;
    for (int i = 0; i < 300; i++) send_word(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    repeat (3) @(negedge SCLK);
    chk("work state", state, 4);
    chk("work in_ready", in_ready, 1);
    chk("work writes", dq_addr.size() - d0, 300);
    bad = 0;
    for (int i = 0; i < dq_addr.size() - d0 && i < 300; i++)
      if (dq_addr[d0+i] != (wptr + i) % DATA_N || dq_zero[d0+i] != 1'b0 || dq_cyc[d0+i] != pq[i] + 1) bad++;
    chk("work write addr/timing", bad, 0);
    chk("wrap at 257th word", (dq_addr.size() > d0 + 256) ? dq_addr[d0+256] : -1, 0);
    chk("cs count", csq.size() - s0, 300);
    bad = 0;
    for (int i = 0; i < csq.size() - s0 && i < 300; i++) if (csq[s0+i] != pq[i] + 2) bad++;
    chk("cs timing", bad, 0);

    // Clear together with a word: word dropped, buffer re-zeroed, memories untouched
    d0 = dq_addr.size(); r0 = rjq.size(); c0 = cfq.size(); n0 = n_det;
    @(posedge SCLK); #1 frame_pulse = 1'b1; clear_req = 1'b1;
    @(posedge SCLK); #1 frame_pulse = 1'b0; clear_req = 1'b0;
    chk("clr state", state, 5);
    chk("clr in_ready", in_ready, 0);
    repeat (10) @(posedge SCLK);
    #1 frame_pulse = 1'b1;
    @(posedge SCLK); #1 frame_pulse = 1'b0;
    wait_state(3, 400, "clr done");
    @(negedge SCLK);
    check_sweep("clear", d0);
    chk("clr det_clear", n_det - n0, 1);
    chk("clr rj untouched", rjq.size() - r0, 0);
    chk("clr coef untouched", cfq.size() - c0, 0);
    chk("clr data_addr", data_addr, 0);
    chk("clr in_ready back", in_ready, 1);

    // Silence handling: all_zeros in WORKING, then zero words, then a nonzero word
    d0 = dq_addr.size(); s0 = csq.size(); n0 = n_det; pq.delete();
    wptr = 0; asleep = 1'b0; exp_cs = 0; exp_det = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        @(posedge SCLK); #1 all_zeros = 1'b1;
        @(posedge SCLK); #1 all_zeros = 1'b0;
        asleep = SLEEP_EN;
        chk("after all_zeros state", state, asleep ? 6 : 4);
      end
      send_word(zs[i], 1);
      if (!asleep) exp_cs++;
      else if (!zs[i]) begin asleep = 1'b0; exp_cs++; exp_det++; end
    end
    repeat (3) @(negedge SCLK);
    chk("sleep final state", state, 4);
    chk("sleep writes", dq_addr.size() - d0, 6);
    bad = 0;
    for (int i = 0; i < dq_addr.size() - d0 && i < 6; i++)
      if (dq_addr[d0+i] != wptr + i || dq_zero[d0+i] != 1'b0) bad++;
    chk("sleep write addrs", bad, 0);
    chk("sleep cs count", csq.size() - s0, exp_cs);
    chk("sleep det_clear", n_det - n0, exp_det);
    chk("wake cs timing", (csq.size() > s0) ? csq[csq.size()-1] : -1, pq[5] + 2);

    // Asynchronous reset in the middle of coefficient word 200
    @(posedge SCLK); #1 rst_n = 1'b0;
    repeat (2) @(posedge SCLK); #1 rst_n = 1'b1;
    wait_state(1, 400, "reinit");
    for (int i = 0; i < RJ_N; i++) send_word(1'b0, 0);
    for (int i = 0; i < 200; i++) send_word(1'b0, 0);
    @(posedge SCLK); #1 frame_pulse = 1'b1;
    @(posedge SCLK); #1 frame_pulse = 1'b0;
    chk("coef200 we", coef_we, 1);
    chk("coef200 addr", coef_addr, 200);
    #2 rst_n = 1'b0;
    #1;
    chk("arst state", state, 0);
    chk("arst coef_addr", coef_addr, 0);
    chk("arst coef_we", coef_we, 0);
    chk("arst in_ready", in_ready, 0);
    d0 = dq_addr.size(); r0 = rjq.size();
    @(posedge SCLK); #1 rst_n = 1'b1;
    wait_state(1, 400, "reload init done");
    check_sweep("reload", d0);
    send_word(1'b0, 0);
    send_word(1'b1, 0);
    repeat (2) @(negedge SCLK);
    chk("reload rj count", rjq.size() - r0, 2);
    chk("reload rj addr0", (rjq.size() > r0) ? rjq[r0] : -1, 0);
    chk("reload rj addr1", (rjq.size() > r0 + 1) ? rjq[r0+1] : -1, 1);
    chk("reload state", state, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
